// File: rtl/sha1_msg_padder_pkg.sv
// Shared types and constants for the SHA1 message padder.
package sha1_msg_padder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_EMIT,
        S_START,
        S_WAIT
    } state_e;

    localparam logic [31:0] SHA1_PAD_WORD = 32'h8000_0000;
    localparam int          BLOCK_WORDS   = 16;

    // Byte counts above a full word are treated as a full word.
    function automatic logic [2:0] clamp_bytes(input logic [2:0] b);
        return (b > 3'd4) ? 3'd4 : b;
    endfunction

endpackage

// File: rtl/sha1_msg_padder_mask.sv
// Final-word formatter: keeps the valid leading bytes, inserts 0x80 after them, zeroes the rest.
module sha1_msg_padder_mask
    import sha1_msg_padder_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  bytes_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [2:0] nb;

    assign nb     = clamp_bytes(bytes_i);
    assign full_o = (nb == 3'd4);

    always_comb begin
        word_o = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nb)
                word_o[31-8*i -: 8] = data_i[31-8*i -: 8];
            else if (3'(i) == nb)
                word_o[31-8*i -: 8] = 8'h80;
        end
    end

endmodule

// File: rtl/sha1_msg_padder.sv
// Streams 32-bit big-endian words into padded 512-bit SHA1 blocks and sequences the core.
module sha1_msg_padder
    import sha1_msg_padder_pkg::*;
#(
    parameter int MAX_BLOCKS = 16,
    parameter int LEN_W      = 64
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [31:0]      in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_last_i,
    input  logic [2:0]       in_bytes_i,
    output logic [511:0]     blk_data_o,
    output logic             blk_wen_o,
    output logic [LEN_W-1:0] blk_num_o,
    output logic             start_o,
    input  logic             done_i,
    output logic             busy_o,
    output logic             err_o
);

    state_e             state_q;
    logic [511:0]       blk_q;
    logic [4:0]         widx_q;
    logic [LEN_W-1:0]   bytecnt_q;
    logic [LEN_W-1:0]   blk_num_q;
    logic               pad_pend_q;
    logic               need2_q;     // 0x80 landed in word 14/15: length goes in the next block
    logic               last_seen_q;
    logic               final_q;
    logic               in_ready_q;
    logic               blk_wen_q;
    logic               start_q;
    logic               busy_q;
    logic               err_q;

    logic               accept;
    logic [31:0]        last_word;
    logic               last_full;
    logic [31:0]        in_word;
    logic [2:0]         nbytes;
    logic [LEN_W-1:0]   bytecnt_d;
    logic [63:0]        len64;
    logic [31:0]        pad_word;
    logic               emit_now;
    logic               ovf;

    sha1_msg_padder_mask u_mask (
        .data_i  (in_data_i),
        .bytes_i (in_bytes_i),
        .word_o  (last_word),
        .full_o  (last_full)
    );

    assign accept    = in_valid_i && in_ready_q;
    assign in_word   = in_last_i ? last_word : in_data_i;
    assign nbytes    = in_last_i ? clamp_bytes(in_bytes_i) : 3'd4;
    assign bytecnt_d = ((state_q == S_IDLE) ? '0 : bytecnt_q) + LEN_W'(nbytes);
    assign len64     = 64'({bytecnt_q, 3'b000});
    assign ovf       = (blk_num_q >= LEN_W'(MAX_BLOCKS));

    always_comb begin
        pad_word = '0;
        if (pad_pend_q)
            pad_word = SHA1_PAD_WORD;
        else if (!need2_q && widx_q == 5'd14)
            pad_word = len64[63:32];
        else if (!need2_q && widx_q == 5'd15)
            pad_word = len64[31:0];
    end

    // Entry into EMIT: a full block is sitting in blk_q this cycle's edge.
    assign emit_now = (accept && !in_last_i && widx_q == 5'(BLOCK_WORDS - 1))
                   || (state_q == S_PAD && widx_q == 5'(BLOCK_WORDS))
                   || (state_q == S_PAD && !pad_pend_q && !need2_q && widx_q == 5'd15);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            blk_q       <= '0;
            widx_q      <= '0;
            bytecnt_q   <= '0;
            blk_num_q   <= '0;
            pad_pend_q  <= 1'b0;
            need2_q     <= 1'b0;
            last_seen_q <= 1'b0;
            final_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            blk_wen_q   <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            blk_wen_q <= 1'b0;
            start_q   <= 1'b0;
            if (emit_now) begin
                if (ovf) begin
                    err_q <= 1'b1;
                end else begin
                    blk_wen_q <= 1'b1;
                    blk_num_q <= blk_num_q + LEN_W'(1);
                end
            end
            case (state_q)
                S_IDLE, S_FILL: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        blk_q     <= {blk_q[479:0], in_word};
                        widx_q    <= widx_q + 5'd1;
                        bytecnt_q <= bytecnt_d;
                        if (state_q == S_IDLE) begin
                            blk_num_q <= '0;
                            err_q     <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                        if (in_last_i) begin
                            state_q     <= S_PAD;
                            in_ready_q  <= 1'b0;
                            last_seen_q <= 1'b1;
                            pad_pend_q  <= last_full;
                            need2_q     <= !last_full && (widx_q >= 5'd14);
                        end else if (widx_q == 5'(BLOCK_WORDS - 1)) begin
                            state_q    <= S_EMIT;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end
                end
                S_PAD: begin
                    if (widx_q == 5'(BLOCK_WORDS)) begin
                        widx_q  <= '0;
                        need2_q <= 1'b0;
                        state_q <= S_EMIT;
                    end else begin
                        blk_q  <= {blk_q[479:0], pad_word};
                        widx_q <= widx_q + 5'd1;
                        if (pad_pend_q) begin
                            pad_pend_q <= 1'b0;
                            need2_q    <= (widx_q >= 5'd14);
                        end else if (!need2_q && widx_q == 5'd15) begin
                            final_q <= 1'b1;
                            state_q <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    widx_q <= '0;
                    if (final_q) begin
                        final_q     <= 1'b0;
                        last_seen_q <= 1'b0;
                        // An overflowed message never starts the core.
                        if (err_q) begin
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= S_START;
                            start_q <= 1'b1;
                        end
                    end else if (last_seen_q) begin
                        state_q <= S_PAD;
                    end else begin
                        state_q    <= S_FILL;
                        in_ready_q <= 1'b1;
                    end
                end
                S_START: state_q <= S_WAIT;
                S_WAIT: begin
                    if (done_i) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign blk_data_o = blk_q;
    assign blk_wen_o  = blk_wen_q;
    assign blk_num_o  = blk_num_q;
    assign start_o    = start_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder: default instance plus a MAX_BLOCKS=2 instance for overflow.
module tb_sha1_msg_padder;

    localparam int LEN_W = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      in_data = '0;
    logic             in_last = 1'b0;
    logic [2:0]       in_bytes = '0;
    logic             in_valid = 1'b0;
    logic             in_valid2 = 1'b0;
    logic             done = 1'b0;
    logic             done2 = 1'b0;
    logic             mon_clr = 1'b0;

    logic             in_ready, blk_wen, start, busy, err;
    logic [511:0]     blk_data;
    logic [LEN_W-1:0] blk_num;
    logic             in_ready2, blk_wen2, start2, busy2, err2;
    logic [511:0]     blk_data2;
    logic [LEN_W-1:0] blk_num2;

    int               checks = 0;
    int               errors = 0;
    int               wen_cnt = 0, start_cnt = 0, wen2_cnt = 0, start2_cnt = 0;
    logic [511:0]     cap [4];
    logic [511:0]     eb;
    logic [511:0]     abc_blk;

    always #5 clk = ~clk;

    sha1_msg_padder #(.MAX_BLOCKS(16), .LEN_W(LEN_W)) u_dut (
        .clk_i(clk), .reset_i(reset), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_last_i(in_last), .in_bytes_i(in_bytes),
        .blk_data_o(blk_data), .blk_wen_o(blk_wen), .blk_num_o(blk_num),
        .start_o(start), .done_i(done), .busy_o(busy), .err_o(err)
    );

    sha1_msg_padder #(.MAX_BLOCKS(2), .LEN_W(LEN_W)) u_dut2 (
        .clk_i(clk), .reset_i(reset), .in_data_i(in_data), .in_valid_i(in_valid2),
        .in_ready_o(in_ready2), .in_last_i(in_last), .in_bytes_i(in_bytes),
        .blk_data_o(blk_data2), .blk_wen_o(blk_wen2), .blk_num_o(blk_num2),
        .start_o(start2), .done_i(done2), .busy_o(busy2), .err_o(err2)
    );

    always @(posedge clk) begin
        if (mon_clr) begin
            wen_cnt    <= 0;
            start_cnt  <= 0;
            wen2_cnt   <= 0;
            start2_cnt <= 0;
        end else begin
            if (blk_wen) begin
                cap[wen_cnt[1:0]] <= blk_data;
                wen_cnt <= wen_cnt + 1;
            end
            if (start)    start_cnt  <= start_cnt + 1;
            if (blk_wen2) wen2_cnt   <= wen2_cnt + 1;
            if (start2)   start2_cnt <= start2_cnt + 1;
        end
    end

    function automatic logic [31:0] pat(input int i);
        return 32'hA5C3_0000 | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        @(negedge clk) mon_clr = 1'b1;
        @(negedge clk) mon_clr = 1'b0;
    endtask

    task automatic send(input int sel, input logic [31:0] d, input logic l,
                        input logic [2:0] b, input bit rnd);
        int n;
        if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        if (sel == 0) in_valid = 1'b1; else in_valid2 = 1'b1;
        n = 0;
        while (((sel == 0) ? !in_ready : !in_ready2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 512'(n), 512'(0));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic wait_start(input int sel, input string tag);
        int n;
        n = 0;
        while (((sel == 0) ? start_cnt : start2_cnt) == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, 512'(n < 300), 512'(1));
    endtask

    task automatic finish_msg(input string tag);
        @(negedge clk) done = 1'b1;
        @(negedge clk) done = 1'b0;
        chk({tag, "_busy_after_done"}, 512'(busy), 512'(0));
        chk({tag, "_ready_after_done"}, 512'(in_ready), 512'(1));
    endtask

    initial begin
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        repeat (2) @(negedge clk);
        chk("rst_ready", 512'(in_ready), 512'(0));
        chk("rst_busy",  512'(busy), 512'(0));
        chk("rst_wen",   512'(blk_wen), 512'(0));
        chk("rst_start", 512'(start), 512'(0));
        chk("rst_err",   512'(err), 512'(0));
        chk("rst_num",   512'(blk_num), 512'(0));
        chk("rst_data",  blk_data, 512'(0));
        @(negedge clk) reset = 1'b0;

        // "abc"
        clr_mon();
        send(0, 32'h61626300, 1'b1, 3'd3, 1'b0);
        wait_start(0, "abc");
        chk("abc_wen_cnt", 512'(wen_cnt), 512'(1));
        chk("abc_block",   cap[0], abc_blk);
        chk("abc_num",     512'(blk_num), 512'(1));
        chk("abc_busy",    512'(busy), 512'(1));
        chk("abc_start_cnt", 512'(start_cnt), 512'(1));
        finish_msg("abc");

        // 119 bytes -> two blocks
        clr_mon();
        for (int i = 0; i < 29; i++) send(0, pat(i), 1'b0, 3'd0, 1'b0);
        send(0, 32'h53AABBCC, 1'b1, 3'd3, 1'b0);
        wait_start(0, "m119");
        chk("m119_wen_cnt", 512'(wen_cnt), 512'(2));
        chk("m119_num", 512'(blk_num), 512'(2));
        for (int k = 0; k < 16; k++) eb[511-32*k -: 32] = pat(k);
        chk("m119_blk0", cap[0], eb);
        eb = '0;
        for (int k = 0; k < 13; k++) eb[511-32*k -: 32] = pat(16 + k);
        eb[511-32*13 -: 32] = 32'h53AABB80;
        eb[31:0] = 32'h000003b8;
        chk("m119_blk1", cap[1], eb);
        chk("m119_err", 512'(err), 512'(0));

        // a word offered while busy must wait for done
        clr_mon();
        @(negedge clk);
        in_data = 32'h61626300; in_last = 1'b1; in_bytes = 3'd3; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold_ready", 512'(in_ready), 512'(0));
        chk("hold_busy",  512'(busy), 512'(1));
        done = 1'b1;
        @(negedge clk) done = 1'b0;
        chk("hold_release_ready", 512'(in_ready), 512'(1));
        chk("hold_release_busy",  512'(busy), 512'(0));
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
        wait_start(0, "hold");
        chk("hold_wen_cnt", 512'(wen_cnt), 512'(1));
        chk("hold_block", cap[0], abc_blk);
        finish_msg("hold");

        // 56 bytes: length spills into a second block; done mid-fill ignored
        clr_mon();
        for (int i = 0; i < 13; i++) begin
            if (i == 5) begin
                @(negedge clk) done = 1'b1;
                @(negedge clk) done = 1'b0;
            end
            send(0, pat(100 + i), 1'b0, 3'd0, 1'b0);
        end
        chk("m56_busy_mid", 512'(busy), 512'(1));
        send(0, pat(113), 1'b1, 3'd4, 1'b0);
        wait_start(0, "m56");
        chk("m56_num", 512'(blk_num), 512'(2));
        eb = '0;
        for (int k = 0; k < 14; k++) eb[511-32*k -: 32] = pat(100 + k);
        eb[63:32] = 32'h80000000;
        chk("m56_blk0", cap[0], eb);
        chk("m56_blk1", cap[1], {480'h0, 32'h000001c0});
        finish_msg("m56");

        // empty message
        clr_mon();
        send(0, 32'hDEADBEEF, 1'b1, 3'd0, 1'b0);
        wait_start(0, "empty");
        chk("empty_block", cap[0], {32'h80000000, 480'h0});
        chk("empty_num", 512'(blk_num), 512'(1));
        finish_msg("empty");

        // overflow on the MAX_BLOCKS=2 instance: 200 bytes needs 4 blocks
        clr_mon();
        for (int i = 0; i < 50; i++) send(1, pat(i), (i == 49), 3'd4, 1'b0);
        begin
            int n;
            n = 0;
            while (busy2 && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("ovf_idle_reached", 512'(n < 300), 512'(1));
        end
        chk("ovf_wen_cnt",   512'(wen2_cnt), 512'(2));
        chk("ovf_err",       512'(err2), 512'(1));
        chk("ovf_no_start",  512'(start2_cnt), 512'(0));
        chk("ovf_num",       512'(blk_num2), 512'(2));
        chk("ovf_ready",     512'(in_ready2), 512'(1));
        clr_mon();
        send(1, 32'h61626300, 1'b1, 3'd3, 1'b0);
        chk("ovf_err_cleared", 512'(err2), 512'(0));
        wait_start(1, "ovf_next");
        chk("ovf_next_wen", 512'(wen2_cnt), 512'(1));
        chk("ovf_next_num", 512'(blk_num2), 512'(1));
        chk("ovf_next_block", blk_data2, abc_blk);
        @(negedge clk) done2 = 1'b1;
        @(negedge clk) done2 = 1'b0;
        chk("ovf_next_idle", 512'(busy2), 512'(0));

        // reset mid-fill discards the message
        for (int i = 0; i < 3; i++) send(0, pat(200 + i), 1'b0, 3'd0, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("mrst_ready", 512'(in_ready), 512'(0));
        chk("mrst_busy",  512'(busy), 512'(0));
        chk("mrst_num",   512'(blk_num), 512'(0));
        chk("mrst_data",  blk_data, 512'(0));
        clr_mon();
        send(0, 32'h61626300, 1'b1, 3'd3, 1'b1);
        wait_start(0, "post_rst_abc");
        chk("post_rst_abc_block", cap[0], abc_blk);
        chk("post_rst_abc_wen",   512'(wen_cnt), 512'(1));
        finish_msg("post_rst_abc");

        // 119 bytes again with random gaps in in_valid
        clr_mon();
        for (int i = 0; i < 29; i++) send(0, pat(i), 1'b0, 3'd0, 1'b1);
        send(0, 32'h53AABBCC, 1'b1, 3'd3, 1'b1);
        wait_start(0, "rnd119");
        chk("rnd119_wen_cnt", 512'(wen_cnt), 512'(2));
        for (int k = 0; k < 16; k++) eb[511-32*k -: 32] = pat(k);
        chk("rnd119_blk0", cap[0], eb);
        eb = '0;
        for (int k = 0; k < 13; k++) eb[511-32*k -: 32] = pat(16 + k);
        eb[511-32*13 -: 32] = 32'h53AABB80;
        eb[31:0] = 32'h000003b8;
        chk("rnd119_blk1", cap[1], eb);
        finish_msg("rnd119");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
